// File: rtl/priv_mem_arbiter.sv
// Round-robin arbiter in front of the privileged memory port. Each request is checked against
// a per-region access-level table, and a denied request never drives a memory strobe.
module priv_mem_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*2-1:0]      req_level,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         priv_addr,
  output logic [DATA_W-1:0]         priv_write_data,
  output logic                      priv_write_enable,
  output logic                      priv_read_enable,
  input  logic [DATA_W-1:0]         priv_read_data,
  input  logic                      viol_clear,
  output logic [CNT_W-1:0]          viol_count,
  output logic                      viol_flag
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, win_q, win_d, cand;
  logic              found;
  logic              write_q, err_q;
  logic [ADDR_W-1:0] priv_addr_q;
  logic [DATA_W-1:0] priv_wdata_q, rsp_rdata_q;
  logic [CNT_W-1:0]  viol_count_q;
  logic              viol_flag_q;

  logic              accept, sel_ok, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_level;

  function automatic logic permitted(logic [1:0] region, logic wr, logic [1:0] lvl);
    case (region)
      2'b00:   return 1'b1;
      2'b01:   return wr ? (lvl >= 2'd2) : (lvl >= 2'd1);
      2'b10:   return lvl >= 2'd2;
      default: return lvl == 2'd3;
    endcase
  endfunction

  // First valid requester after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win_d = ptr_q;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win_d = cand;
      end
    end
  end

  always_comb begin
    sel_write = req_write[win_d];
    sel_addr  = req_addr[win_d*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[win_d*DATA_W +: DATA_W];
    sel_level = req_level[win_d*2 +: 2];
    sel_ok    = permitted(sel_addr[ADDR_W-1:ADDR_W-2], sel_write, sel_level);
    accept    = (state_q == IDLE) && found;
    req_ready = accept ? (NUM_REQ'(1) << win_d) : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = sel_ok ? ACCESS : RESP;
      ACCESS:  state_d = write_q ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      win_q        <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      priv_addr_q  <= '0;
      priv_wdata_q <= '0;
      rsp_rdata_q  <= '0;
      viol_count_q <= '0;
      viol_flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_q       <= win_d;
        write_q     <= sel_write;
        err_q       <= !sel_ok;
        rsp_rdata_q <= '0;
        // Memory-side registers only move for permitted requests.
        if (sel_ok) begin
          priv_addr_q <= sel_addr;
          if (sel_write) priv_wdata_q <= sel_wdata;
        end
      end
      if (state_q == CAPTURE) rsp_rdata_q <= priv_read_data;
      if (state_q == RESP) ptr_q <= win_q;
      if (viol_clear) begin
        viol_count_q <= '0;
        viol_flag_q  <= 1'b0;
      end else if (accept && !sel_ok) begin
        if (viol_count_q != '1) viol_count_q <= viol_count_q + CNT_W'(1);
        viol_flag_q <= 1'b1;
      end
    end
  end

  always_comb begin
    priv_addr         = priv_addr_q;
    priv_write_data   = priv_wdata_q;
    priv_read_enable  = (state_q == ACCESS) && !write_q;
    priv_write_enable = (state_q == ACCESS) && write_q;
    rsp_valid         = (state_q == RESP) ? (NUM_REQ'(1) << win_q) : '0;
    rsp_err           = (state_q == RESP) && err_q;
    rsp_rdata         = rsp_rdata_q;
    viol_count        = viol_count_q;
    viol_flag         = viol_flag_q;
  end

endmodule

// File: tb/tb_priv_mem_arbiter.sv
// Scoreboard bench for priv_mem_arbiter: accepts push expected responses, responses pop them.
// The counter width is narrowed so saturation is reachable in a short run.
module tb_priv_mem_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*2-1:0]  req_level;
  logic [DW-1:0]    rsp_rdata, priv_write_data, priv_read_data;
  logic             rsp_err, priv_write_enable, priv_read_enable, viol_clear, viol_flag;
  logic [AW-1:0]    priv_addr;
  logic [CW-1:0]    viol_count;

  always #5 clk = ~clk;

  priv_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_level(req_level),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .priv_addr(priv_addr),
    .priv_write_data(priv_write_data), .priv_write_enable(priv_write_enable),
    .priv_read_enable(priv_read_enable), .priv_read_data(priv_read_data),
    .viol_clear(viol_clear), .viol_count(viol_count), .viol_flag(viol_flag)
  );

  typedef struct {
    int          idx;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  rsp_t        sb[$];
  int          grants[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rr_ptr = NR - 1;
  int          exp_strobe_cyc = -1;
  bit          exp_strobe_wr;
  logic [7:0]  exp_strobe_addr;
  logic [31:0] exp_strobe_data;
  int          exp_cnt = 0;
  bit          exp_flag = 0;
  int          last_rsp_cyc = -10;
  bit          mon_en = 0;
  logic [31:0] mem [256];

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit allowed(logic [7:0] a, bit wr, logic [1:0] l);
    case (a[7:6])
      2'b00:   return 1'b1;
      2'b01:   return wr ? (l >= 2) : (l >= 1);
      2'b10:   return l >= 2;
      default: return l == 3;
    endcase
  endfunction

  function automatic logic [31:0] init_val(int a);
    return (a == 5) ? 32'hDEADBEEF : (32'h5A5A0000 | (32'(a) * 32'h00000101));
  endfunction

  // Privileged memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
      priv_read_data <= '0;
    end else begin
      if (priv_write_enable) mem[priv_addr] <= priv_write_data;
      if (priv_read_enable) priv_read_data <= mem[priv_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    rsp_t       e;
    int         w;
    bit         ok, wr;
    logic [7:0] a;
    if (mon_en && !reset) begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_valid", rsp_valid, 64'(1) << e.idx);
          check_eq("rsp_err", rsp_err, e.err);
          check_eq("rsp_rdata", rsp_rdata, e.rdata);
          check_eq("rsp_latency", cyc, e.due);
        end
        check_eq("viol_count", viol_count, exp_cnt);
        check_eq("viol_flag", viol_flag, exp_flag);
        last_rsp_cyc = cyc;
      end
      if (priv_write_enable || priv_read_enable || cyc == exp_strobe_cyc) begin
        check_eq("strobe_cycle", cyc, exp_strobe_cyc);
        check_eq("strobe_we", priv_write_enable, exp_strobe_wr);
        check_eq("strobe_re", priv_read_enable, !exp_strobe_wr);
        check_eq("priv_addr", priv_addr, exp_strobe_addr);
        if (exp_strobe_wr) check_eq("priv_wdata", priv_write_data, exp_strobe_data);
        exp_strobe_cyc = -1;
      end
      if (req_ready != '0) begin
        w = rr_ptr;
        for (int k = NR; k >= 1; k--) if (req_valid[(rr_ptr + k) % NR]) w = (rr_ptr + k) % NR;
        check_eq("grant", req_ready, 64'(1) << w);
        check_eq("accept_when_busy", (sb.size() != 0) || (cyc == last_rsp_cyc), 0);
        a  = req_addr[w*AW +: AW];
        wr = req_write[w];
        ok = allowed(a, wr, req_level[w*2 +: 2]);
        e.idx   = w;
        e.err   = !ok;
        e.rdata = (ok && !wr) ? mem[a] : 32'h0;
        e.due   = cyc + (!ok ? 1 : (wr ? 2 : 3));
        sb.push_back(e);
        if (ok) begin
          exp_strobe_cyc  = cyc + 1;
          exp_strobe_wr   = wr;
          exp_strobe_addr = a;
          exp_strobe_data = req_wdata[w*DW +: DW];
        end
        grants.push_back(w);
        rr_ptr = w;
        if (!ok) begin
          if (exp_cnt < (1 << CW) - 1) exp_cnt++;
          exp_flag = 1;
        end
      end
      if (viol_clear) begin
        exp_cnt  = 0;
        exp_flag = 0;
      end
    end
  end

  task automatic flush_model();
    sb.delete();
    rr_ptr         = NR - 1;
    exp_cnt        = 0;
    exp_flag       = 0;
    exp_strobe_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic do_req(int i, bit wr, logic [7:0] a, logic [31:0] d, logic [1:0] l);
    bit got = 0;
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_level[i*2 +: 2] = l;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    if (!got) check_eq("accept_timeout", got, 1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) return;
    end
    check_eq("rsp_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic txn(int i, bit wr, logic [7:0] a, logic [31:0] d, logic [1:0] l);
    do_req(i, wr, a, d, l);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_level = '0;
    viol_clear = 1'b0;
    @(posedge clk);
    #1 do_reset();
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_we", priv_write_enable, 0);
    check_eq("rst_re", priv_read_enable, 0);
    check_eq("rst_priv_addr", priv_addr, 0);
    check_eq("rst_priv_wdata", priv_write_data, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_viol_count", viol_count, 0);
    check_eq("rst_viol_flag", viol_flag, 0);
    @(posedge clk);
    #1 mon_en = 1'b1;

    txn(0, 1'b0, 8'h05, 32'h0, 2'd0);
    txn(2, 1'b1, 8'hC1, 32'h12345678, 2'd2);
    check_eq("deny_count", viol_count, 1);
    check_eq("deny_flag", viol_flag, 1);
    txn(1, 1'b1, 8'h41, 32'hA5A5A5A5, 2'd1);
    txn(1, 1'b1, 8'h41, 32'hA5A5A5A5, 2'd2);
    check_eq("mem_41", mem[8'h41], 32'hA5A5A5A5);
    check_eq("deny_count2", viol_count, 2);

    // All requesters contend with permitted reads.
    do_reset();
    grants.delete();
    for (int i = 0; i < NR; i++) begin
      req_write[i] = 1'b0;
      req_addr[i*AW +: AW] = 8'(8'h10 + i);
      req_level[i*2 +: 2] = 2'd0;
    end
    req_valid = '1;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk);
      #1;
      if (grants.size() >= 5) break;
    end
    req_valid = '0;
    wait_done();
    for (int k = 0; k < 5; k++) check_eq("rr_order", (k < grants.size()) ? grants[k] : -1, k % NR);

    for (int r = 0; r < 4; r++)
      for (int l = 0; l < 4; l++)
        for (int wr = 0; wr < 2; wr++)
          txn(3, wr[0], {r[1:0], 6'h0A}, 32'hC0DE0000 | 32'(r * 16 + l), l[1:0]);

    for (int n = 0; n < 300; n++) txn(2, 1'b1, 8'hC0, 32'h0, 2'd0);
    check_eq("sat_count", viol_count, 8'hFF);
    check_eq("sat_flag", viol_flag, 1);
    viol_clear = 1'b1;
    txn(1, 1'b0, 8'hFF, 32'h0, 2'd2);
    viol_clear = 1'b0;
    check_eq("clr_count", viol_count, 0);
    check_eq("clr_flag", viol_flag, 0);

    // Reset lands while a read is in CAPTURE.
    do_req(0, 1'b0, 8'h07, 32'h0, 2'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    flush_model();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    check_eq("midrst_rsp_err", rsp_err, 0);
    check_eq("midrst_we", priv_write_enable, 0);
    check_eq("midrst_re", priv_read_enable, 0);
    repeat (3) @(posedge clk);
    #2 txn(0, 1'b0, 8'h05, 32'h0, 2'd0);
    check_eq("post_rst_rdata", rsp_rdata, 32'hDEADBEEF);

    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
